// File: rtl/md_audio_pkg.sv
// md_audio_pkg -- shared defaults, sample type and saturation helper for the audio mixer.
// Revision: 1.0
`default_nettype none

package md_audio_pkg;

  localparam int          DIV_LOG2_DEF  = 10;
  localparam int          FM_SHIFT_DEF  = 5;
  localparam int          PSG_SHIFT_DEF = 2;
  localparam logic [15:0] PSG_DC_DEF    = 16'h0000;

  typedef logic signed [15:0] sample_t;

  localparam int SAT_MAX = 32767;
  localparam int SAT_MIN = -32768;

  function automatic sample_t sat19(input logic signed [18:0] x);
    if (x > SAT_MAX)      return sample_t'(SAT_MAX);
    else if (x < SAT_MIN) return sample_t'(SAT_MIN);
    else                  return x[15:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/md_audio_fifo.sv
// md_audio_fifo -- 2-entry stereo sample FIFO, valid/ready drain, sticky overflow on dropped push.
// Revision: 1.0
`default_nettype none

module md_audio_fifo
  import md_audio_pkg::*;
(
  input  logic    clk_i,
  input  logic    srst_n_i,
  input  logic    push_i,
  input  sample_t push_l_i,
  input  sample_t push_r_i,
  input  logic    ready_i,
  output logic    valid_o,
  output sample_t l_o,
  output sample_t r_o,
  output logic    overflow_o
);

  sample_t    mem_l_q [2];
  sample_t    mem_r_q [2];
  logic       rd_q;
  logic [1:0] cnt_q, cnt_d;
  logic       ovf_q;

  logic w_pop, w_full, w_accept, w_wr_idx;

  assign w_pop    = valid_o && ready_i;
  assign w_full   = (cnt_q == 2'd2);
  assign w_accept = push_i && (!w_full || w_pop);
  // With two entries the free slot is rd^count[0]; when full it is the slot being popped.
  assign w_wr_idx = rd_q ^ cnt_q[0];

  always_comb begin
    cnt_d = cnt_q;
    if (w_accept && !w_pop)      cnt_d = cnt_q + 2'd1;
    else if (!w_accept && w_pop) cnt_d = cnt_q - 2'd1;
  end

  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      mem_l_q[0] <= '0;
      mem_l_q[1] <= '0;
      mem_r_q[0] <= '0;
      mem_r_q[1] <= '0;
      rd_q       <= 1'b0;
      cnt_q      <= 2'd0;
      ovf_q      <= 1'b0;
    end else begin
      if (w_accept) begin
        mem_l_q[w_wr_idx] <= push_l_i;
        mem_r_q[w_wr_idx] <= push_r_i;
      end
      rd_q  <= rd_q ^ w_pop;
      cnt_q <= cnt_d;
      ovf_q <= ovf_q | (push_i && w_full && !w_pop);
    end
  end

  assign valid_o    = (cnt_q != 2'd0);
  assign l_o        = valid_o ? mem_l_q[rd_q] : '0;
  assign r_o        = valid_o ? mem_r_q[rd_q] : '0;
  assign overflow_o = ovf_q;

endmodule

`default_nettype wire

// File: rtl/md_audio_mixer.sv
// md_audio_mixer -- box-filter decimation of FM/PSG audio, mix with saturation, 2-deep output FIFO.
// Revision: 1.0
`default_nettype none

module md_audio_mixer
  import md_audio_pkg::*;
#(
  parameter int          DIV_LOG2  = DIV_LOG2_DEF,
  parameter int          FM_SHIFT  = FM_SHIFT_DEF,
  parameter int          PSG_SHIFT = PSG_SHIFT_DEF,
  parameter logic [15:0] PSG_DC    = PSG_DC_DEF
) (
  input  logic              MCLK,
  input  logic              SRES,
  input  logic signed [8:0] MOL,
  input  logic signed [8:0] MOR,
  input  logic [15:0]       PSG,
  input  logic              fm_mute,
  input  logic              psg_mute,
  output sample_t           out_l,
  output sample_t           out_r,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overflow
);

  localparam int                  AW  = 9 + DIV_LOG2;
  localparam int                  PW  = 16 + DIV_LOG2;
  localparam logic [DIV_LOG2-1:0] ONE = DIV_LOG2'(1);

  logic [DIV_LOG2-1:0]   cnt_q;
  logic signed [AW-1:0]  acc_l_q, acc_r_q, acc_l_d, acc_r_d;
  logic [PW-1:0]         acc_p_q, acc_p_d;
  // Compute stage keeps only the window averages (sum >> DIV_LOG2).
  logic signed [8:0]     avg_l_q, avg_r_q;
  logic [15:0]           avg_p_q;
  logic                  fm_mute_q, psg_mute_q, cmp_vld_q;

  logic                  w_win_end;
  logic signed [18:0]    w_fm_l, w_fm_r, w_ps;
  logic signed [16:0]    w_ps_diff, w_ps_shr;
  sample_t               w_mix_l, w_mix_r;

  assign w_win_end = (cnt_q == '1);
  assign acc_l_d   = acc_l_q + {{DIV_LOG2{MOL[8]}}, MOL};
  assign acc_r_d   = acc_r_q + {{DIV_LOG2{MOR[8]}}, MOR};
  assign acc_p_d   = acc_p_q + {{DIV_LOG2{1'b0}}, PSG};

  always_ff @(posedge MCLK) begin
    if (!SRES) begin
      cnt_q      <= '0;
      acc_l_q    <= '0;
      acc_r_q    <= '0;
      acc_p_q    <= '0;
      avg_l_q    <= '0;
      avg_r_q    <= '0;
      avg_p_q    <= '0;
      fm_mute_q  <= 1'b0;
      psg_mute_q <= 1'b0;
      cmp_vld_q  <= 1'b0;
    end else begin
      cnt_q     <= cnt_q + ONE;
      cmp_vld_q <= w_win_end;
      if (w_win_end) begin
        avg_l_q    <= acc_l_d[AW-1:DIV_LOG2];
        avg_r_q    <= acc_r_d[AW-1:DIV_LOG2];
        avg_p_q    <= acc_p_d[PW-1:DIV_LOG2];
        fm_mute_q  <= fm_mute;
        psg_mute_q <= psg_mute;
        acc_l_q    <= '0;
        acc_r_q    <= '0;
        acc_p_q    <= '0;
      end else begin
        acc_l_q <= acc_l_d;
        acc_r_q <= acc_r_d;
        acc_p_q <= acc_p_d;
      end
    end
  end

  always_comb begin
    w_fm_l    = '0;
    w_fm_r    = '0;
    w_ps      = '0;
    w_ps_diff = $signed({1'b0, avg_p_q}) - $signed({1'b0, PSG_DC});
    w_ps_shr  = w_ps_diff >>> PSG_SHIFT;
    if (!fm_mute_q) begin
      w_fm_l = {{10{avg_l_q[8]}}, avg_l_q} <<< FM_SHIFT;
      w_fm_r = {{10{avg_r_q[8]}}, avg_r_q} <<< FM_SHIFT;
    end
    if (!psg_mute_q) w_ps = {{2{w_ps_shr[16]}}, w_ps_shr};
    w_mix_l = sat19(w_fm_l + w_ps);
    w_mix_r = sat19(w_fm_r + w_ps);
  end

  md_audio_fifo u_fifo (
    .clk_i      (MCLK),
    .srst_n_i   (SRES),
    .push_i     (cmp_vld_q),
    .push_l_i   (w_mix_l),
    .push_r_i   (w_mix_r),
    .ready_i    (out_ready),
    .valid_o    (out_valid),
    .l_o        (out_l),
    .r_o        (out_r),
    .overflow_o (overflow)
  );

endmodule

`default_nettype wire

// File: doc/md_audio_mixer.md
MD_AUDIO_MIXER -- requirements
Module: md_audio_mixer

Interface
REQ-001 Parameter DIV_LOG2, default 10: decimation window is 2^DIV_LOG2 MCLK cycles, giving a 52.4 kHz output rate at the 53.69 MHz MCLK.
REQ-002 Parameter FM_SHIFT, default 5: left shift applied to the averaged FM sample.
REQ-003 Parameter PSG_SHIFT, default 2: arithmetic right shift applied to the DC-corrected PSG sample.
REQ-004 Parameter PSG_DC, default 16'h0000: DC offset subtracted from the averaged PSG value.
REQ-005 MCLK  input  1  master clock; every register is clocked on the rising edge.
REQ-006 SRES  input  1  reset; synchronous and active-low.
REQ-007 MOL  input  9  FM left sample, two's complement, may change every MCLK.
REQ-008 MOR  input  9  FM right sample, two's complement.
REQ-009 PSG  input  16  PSG level, unsigned.
REQ-010 fm_mute  input  1  forces the FM contribution of the current window to 0.
REQ-011 psg_mute  input  1  forces the PSG contribution of the current window to 0.
REQ-012 out_l  output  16  mixed left sample, signed, head of the FIFO.
REQ-013 out_r  output  16  mixed right sample, signed.
REQ-014 out_valid  output  1  FIFO non-empty.
REQ-015 out_ready  input  1  consumer accepts the head entry when out_valid=1 and out_ready=1.
REQ-016 overflow  output  1  sticky flag; set when a sample is dropped.

Function
REQ-017 Window counter: DIV_LOG2 bits, increments every MCLK, wraps from 2^DIV_LOG2-1 to 0.
REQ-018 Accumulators acc_l, acc_r, acc_p add MOL, MOR (sign-extended) and PSG (zero-extended) every cycle.
- acc_l/acc_r width: 9+DIV_LOG2 bits.
- acc_p width: 16+DIV_LOG2 bits.
- No overflow is possible at these widths.
REQ-019 Window-end cycle (counter at max):
- The sums including the current input are latched into the compute stage.
- The accumulators load 0 for the next window; no sample is lost or double-counted.
- fm_mute and psg_mute are sampled in this cycle.
REQ-020 Compute stage, one cycle:
- fm = (acc >>> DIV_LOG2) << FM_SHIFT.
- ps = ((acc_p >> DIV_LOG2) - PSG_DC), taken as 17-bit signed, then >>> PSG_SHIFT.
- Muted terms are 0.
- sum = fm + ps in 19-bit signed, saturated to the range [-32768, 32767].
REQ-021 The result is pushed into the FIFO on the cycle after the compute stage.
- Latency: out_valid rises 2 MCLK cycles after the window-end cycle when the FIFO is empty.
REQ-022 FIFO: 2 entries, first-in first-out; out_l/out_r always show the head entry; outputs are 0 when the FIFO is empty.
REQ-023 Simultaneous push and pop:
- Both take effect in the same cycle.
- When the FIFO is full, the pop frees a slot and the push is accepted.
REQ-024 Push while full without a pop:
- The new sample is dropped.
- FIFO contents are unchanged.
- overflow=1 from the next cycle.
REQ-025 out_l/out_r remain stable while out_valid=1 and out_ready=0.

Reset
REQ-026 While SRES=0 at a clock edge, the following are cleared:
- counter, accumulators, compute stage, FIFO;
- out_valid=0, out_l=0, out_r=0, overflow=0.
REQ-027 Reset mid-window discards the partial sums; the first window after release spans exactly 2^DIV_LOG2 cycles starting at the first cycle with SRES=1.
REQ-028 Reset aborts any in-flight compute or push; no sample from before reset appears at the outputs.

Structure
REQ-029 Package md_audio_pkg holds the parameter defaults, the sample typedef (16-bit signed) and the saturation limits.
REQ-030 The FIFO is a single sub-module, md_audio_fifo (2-entry, valid/ready, overflow detect).
REQ-031 The remaining logic (counter, accumulators, compute stage, saturation) is flat in md_audio_mixer.

Verification (DIV_LOG2=2 on the bench)
REQ-032 MOL=+100, MOR=-100, PSG=0, out_ready=1 -> out_l=16'h0C80 and out_r=16'hF380 each window; out_valid pulses 1 cycle per 4 cycles.
REQ-033 MOL=255, PSG=16'hFFFF, PSG_SHIFT=0 -> out_l=16'h7FFF; MOL=-256, PSG=0, PSG_DC=16'h8000, PSG_SHIFT=0 -> out_l=16'h8000.
REQ-034 MOL alternating +8/-8 each cycle, PSG=16'h0040, PSG_DC=0 -> out_l=16'h0010.
REQ-035 out_ready=0 for 3 windows -> the first two samples are held in order, the third is dropped, overflow=1; on out_ready=1 the two samples drain in order and overflow stays 1.
REQ-036 SRES=0 for one cycle at counter=2 with the FIFO full -> next cycle out_valid=0, overflow=0; first new out_valid appears 6 cycles after reset release.
REQ-037 fm_mute=1 only during a window-end cycle with MOL=+100, PSG=16'h0100 -> that sample's out_l=16'h0040; the next sample's out_l=16'h0CC0.
